// File: rtl/upsample_pkg.sv
// Shared definitions for the 1:2 row upsampler: FSM state encoding and default pixel width.
package upsample_pkg;

    localparam int unsigned DEFAULT_LENGTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT_P,
        EMIT_Q,
        TAIL
    } state_t;

endpackage

// File: rtl/upsample_1x2.sv
// 1:2 interpolation kernel: p leans 3/4 towards a, q leans 3/4 towards b, truncating shifts.
module upsample_1x2
    import upsample_pkg::*;
#(
    parameter int length = DEFAULT_LENGTH
) (
    input  logic [length-1:0] a,
    input  logic [length-1:0] b,
    output logic [length-1:0] p,
    output logic [length-1:0] q
);

    // Each term is shifted before adding, so the sum peaks just below 2**length.
    assign p = (a >> 1) + (a >> 2) + (b >> 2);
    assign q = (b >> 1) + (b >> 2) + (a >> 2);

endmodule

// File: rtl/upsample_row_ctrl.sv
// Row controller: turns an N-pixel row into 2N interpolated pixels with ready/valid on both sides.
// Define UPSAMPLE_ROW_NN_EN to add the nn_mode input (per-row pixel replication instead of interpolation).
module upsample_row_ctrl
    import upsample_pkg::*;
#(
    parameter int length = DEFAULT_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [length-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [length-1:0] m_data,
    output logic              m_last,
`ifdef UPSAMPLE_ROW_NN_EN
    input  logic              nn_mode,
`endif
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [length-1:0] prev;
    logic [length-1:0] cur;
    logic              last_seen;
    logic              accept;
    logic [length-1:0] kern_a;
    logic [length-1:0] kern_p;
    logic [length-1:0] kern_q;
    logic [length-1:0] p_sel;
    logic [length-1:0] q_sel;

    assign accept = s_valid & s_ready;
    assign busy   = (state != IDLE);

    // The tail pixel is p(cur,cur); elsewhere the pair is (prev,cur).
    assign kern_a = (state == TAIL) ? cur : prev;

    upsample_1x2 #(.length(length)) u_kernel (
        .a (kern_a),
        .b (cur),
        .p (kern_p),
        .q (kern_q)
    );

`ifdef UPSAMPLE_ROW_NN_EN
    logic nn_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nn_row <= 1'b0;
        end else if (accept && state == IDLE) begin
            nn_row <= nn_mode;
        end
    end

    assign p_sel = nn_row ? kern_a : kern_p;
    assign q_sel = nn_row ? cur    : kern_q;
`else
    assign p_sel = kern_p;
    assign q_sel = kern_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel pair only moves on an accepted input, which keeps m_data stable under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= '0;
            cur       <= '0;
            last_seen <= 1'b0;
        end else if (accept) begin
            prev      <= (state == IDLE) ? s_data : cur;
            cur       <= s_data;
            last_seen <= s_last;
        end
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        case (state)
            IDLE: begin
                s_ready = ~rst;
                if (accept) state_nxt = EMIT_Q;
            end
            LOAD: begin
                s_ready = ~rst;
                if (accept) state_nxt = EMIT_P;
            end
            EMIT_P: begin
                m_valid = 1'b1;
                m_data  = p_sel;
                if (m_ready) state_nxt = EMIT_Q;
            end
            EMIT_Q: begin
                m_valid = 1'b1;
                m_data  = q_sel;
                if (m_ready) state_nxt = last_seen ? TAIL : LOAD;
            end
            TAIL: begin
                m_valid = 1'b1;
                m_data  = p_sel;
                m_last  = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_upsample_row_ctrl.sv
// Self-checking bench for upsample_row_ctrl: directed rows plus randomized rows against a row-level model.
module tb_upsample_row_ctrl;
    import upsample_pkg::*;

    localparam int W = DEFAULT_LENGTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
`ifdef UPSAMPLE_ROW_NN_EN
    logic         nn_mode;
`endif

    upsample_row_ctrl #(.length(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
`ifdef UPSAMPLE_ROW_NN_EN
        .nn_mode (nn_mode),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int row[$];
    int got_d[$];
    bit got_l[$];
    int exp_d[$];
    bit exp_l[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int kp(input int a, input int b, input bit nn);
        return nn ? a : (a >> 1) + (a >> 2) + (b >> 2);
    endfunction

    function automatic int kq(input int a, input int b, input bit nn);
        return nn ? b : (b >> 1) + (b >> 2) + (a >> 2);
    endfunction

    // Expected row output: q(x0,x0), p/q of each adjacent pair, then p(xN-1,xN-1) with last.
    task automatic build_expected(input bit nn);
        int n;
        n = row.size();
        exp_d.delete();
        exp_l.delete();
        exp_d.push_back(kq(row[0], row[0], nn)); exp_l.push_back(1'b0);
        for (int i = 1; i < n; i++) begin
            exp_d.push_back(kp(row[i-1], row[i], nn)); exp_l.push_back(1'b0);
            exp_d.push_back(kq(row[i-1], row[i], nn)); exp_l.push_back(1'b0);
        end
        exp_d.push_back(kp(row[n-1], row[n-1], nn)); exp_l.push_back(1'b1);
    endtask

    task automatic compare_row(input string tag);
        check({tag, "_count"}, got_d.size(), exp_d.size());
        for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
            check($sformatf("%s_data%0d", tag, k), got_d[k], exp_d[k]);
            check($sformatf("%s_last%0d", tag, k), got_l[k], exp_l[k]);
        end
    endtask

    // Streams row[] in and collects outputs; stall_at forces m_ready low for 5 cycles,
    // abort_at returns right after that cycle's sample with inputs still driven.
    task automatic run_row(input bit nn, input bit rnd, input int stall_at, input int abort_at,
                           output int cycles);
        int idx;
        bit pstall;
        int pdata;
        bit plast;
        idx    = 0;
        pstall = 1'b0;
        pdata  = 0;
        plast  = 1'b0;
        cycles = 0;
        got_d.delete();
        got_l.delete();
        while (got_d.size() < 2 * row.size() && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            s_valid = (idx < row.size()) && (!rnd || $urandom_range(0, 3) != 0);
            s_data  = (idx < row.size()) ? W'(row[idx]) : '0;
            s_last  = (idx == row.size() - 1);
`ifdef UPSAMPLE_ROW_NN_EN
            nn_mode = (idx == 0) ? nn : 1'($urandom);
`endif
            m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (cycles >= stall_at && cycles < stall_at + 5) m_ready = 1'b0;
            @(negedge clk);
            if (pstall) begin
                check("stall_data", m_data, pdata);
                check("stall_last", m_last, plast);
            end
            if (m_valid) check("s_ready_while_emit", s_ready, 0);
            pstall = m_valid && !m_ready;
            pdata  = m_data;
            plast  = m_last;
            if (s_valid && s_ready) idx++;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
            end
            if (cycles == abort_at) return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("busy_after_row", busy, 0);
        check("m_valid_after_row", m_valid, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"},  m_last,  0);
        check({tag, "_m_data"},  m_data,  0);
        check({tag, "_busy"},    busy,    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit nn;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
`ifdef UPSAMPLE_ROW_NN_EN
        nn_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        s_valid = 1'b1;
        #1;
        check_idle_zero("reset");
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two-pixel row with free-running downstream.
        row = '{'h0400, 'h0800};
        run_row(1'b0, 1'b0, 1000, -1, cyc);
        exp_d = '{'h0400, 'h0500, 'h0700, 'h0800};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_row("row2");

        // Single-pixel row.
        row = '{'h0003};
        run_row(1'b0, 1'b0, 1000, -1, cyc);
        exp_d = '{'h0001, 'h0001};
        exp_l = '{1'b0, 1'b1};
        compare_row("row1");

        // Back-pressure held for 5 cycles while p is presented.
        row = '{'h0400, 'h0800};
        run_row(1'b0, 1'b0, 4, -1, cyc);
        exp_d = '{'h0400, 'h0500, 'h0700, 'h0800};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_row("stall");
        check("stall_cycles", cyc, 3 * 2 + 5);

        // Reset while emitting q of the second pixel of a 4-pixel row.
        row = '{};
        for (int i = 0; i < 4; i++) row.push_back(int'($urandom_range(0, 16'hffff)));
        run_row(1'b0, 1'b0, 1000, 5, cyc);
        check("abort_in_emit", m_valid, 1);
        rst     = 1'b1;
        s_valid = 1'b0;
        #1;
        check_idle_zero("midrow_rst");
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_m_valid", m_valid, 0);
            check("post_rst_busy", busy, 0);
        end
        row = '{'h0400, 'h0800};
        run_row(1'b0, 1'b0, 1000, -1, cyc);
        exp_d = '{'h0400, 'h0500, 'h0700, 'h0800};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_row("after_rst");

`ifdef UPSAMPLE_ROW_NN_EN
        row = '{'h0123, 'h0456};
        run_row(1'b1, 1'b0, 1000, -1, cyc);
        exp_d = '{'h0123, 'h0123, 'h0456, 'h0456};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        compare_row("nn");
`endif

        // Eight pixels, no gaps on either side: 3 cycles per pixel overall.
        row = '{};
        for (int i = 0; i < 8; i++) row.push_back(int'($urandom_range(0, 16'hffff)));
        run_row(1'b0, 1'b0, 1000, -1, cyc);
        build_expected(1'b0);
        compare_row("row8");
        check("row8_cycles", cyc, 3 * 8);

        // Randomized rows with random valid/ready gaps.
        for (int r = 0; r < 12; r++) begin
            row = '{};
            for (int i = 0; i < int'($urandom_range(1, 9)); i++)
                row.push_back(int'($urandom_range(0, 16'hffff)));
`ifdef UPSAMPLE_ROW_NN_EN
            nn = 1'($urandom);
`else
            nn = 1'b0;
`endif
            run_row(nn, 1'b1, 1000, -1, cyc);
            build_expected(nn);
            compare_row($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upsample_row_ctrl.md
UPSAMPLE_ROW_CTRL -- requirements
Module: upsample_row_ctrl

Interface
REQ-001 Parameter SHALL be: length, 16, pixel width in bits (unsigned fixed-point).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 s_valid  input  1  input pixel valid.
REQ-005 s_ready  output  1  input pixel accepted when s_valid & s_ready.
REQ-006 s_data  input  length  input pixel.
REQ-007 s_last  input  1  marks final pixel of the row.
REQ-008 m_valid  output  1  output pixel valid.
REQ-009 m_ready  input  1  downstream accepts when m_valid & m_ready.
REQ-010 m_data  output  length  upsampled pixel.
REQ-011 m_last  output  1  marks final output pixel of the row.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Kernel SHALL compute, with unsigned truncating shifts and no overflow: p = (a>>1)+(a>>2)+(b>>2); q = (b>>1)+(b>>2)+(a>>2).
REQ-014 Registers prev and cur SHALL hold the pair (a=prev, b=cur); m_data SHALL equal p or q of that pair.
REQ-015 For an N-pixel row x0..x(N-1), output SHALL be exactly 2N pixels: q(x0,x0), then p,q of each (x(i-1),x(i)) for i=1..N-1, then p(x(N-1),x(N-1)).
REQ-016 FSM states SHALL be IDLE, LOAD, EMIT_P, EMIT_Q, TAIL.
REQ-017 IDLE: s_ready=1; on accept, prev<=x, cur<=x, last_seen<=s_last, go EMIT_Q.
REQ-018 LOAD: s_ready=1; on accept, prev<=cur, cur<=x, last_seen<=s_last, go EMIT_P.
REQ-019 EMIT_P: m_valid=1, m_data=p; on m_ready go EMIT_Q.
REQ-020 EMIT_Q: m_valid=1, m_data=q; on m_ready go TAIL if last_seen, else LOAD.
REQ-021 TAIL: m_valid=1, m_data=p(cur,cur), m_last=1; on m_ready go IDLE.
REQ-022 s_ready SHALL be 0 in EMIT_P, EMIT_Q, TAIL, and SHALL NOT depend combinationally on s_valid or m_ready.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable.
REQ-024 m_last SHALL be 0 outside TAIL; N=1 SHALL yield q(x0,x0) then p(x0,x0) with m_last.
REQ-025 With continuous m_ready=1, interior pixels SHALL take 3 cycles each (LOAD, EMIT_P, EMIT_Q).

Reset
REQ-026 On rst: state=IDLE, prev=cur=0, last_seen=0, m_valid=0, m_last=0, m_data=0, busy=0; s_ready SHALL be 0 while rst is high.
REQ-027 Reset mid-row SHALL discard the partial row; no output after release until a new row is accepted.

Configuration
REQ-028 Macro UPSAMPLE_ROW_NN_EN SHALL, when defined, add input nn_mode (1 bit), sampled on the first-pixel accept in IDLE and held for the row; nn_mode=1 makes p=a, q=b (pixel replication).
REQ-029 Without UPSAMPLE_ROW_NN_EN, port nn_mode SHALL not exist and interpolation per REQ-013 SHALL always apply.

Structure
REQ-030 Package upsample_pkg SHALL hold the FSM state enum and the default pixel width constant.
REQ-031 Kernel arithmetic SHALL live in one sub-module, upsample_1x2 (ports a, b, p, q), instantiated once.

Verification
REQ-032 Row [0x0400, 0x0800], m_ready=1 -> m_data 0x0400, 0x0500, 0x0700, 0x0800; m_last only on 4th.
REQ-033 Row [0x0003] (N=1) -> 0x0001, 0x0001; m_last on 2nd; busy low afterwards.
REQ-034 m_ready held 0 for 5 cycles in EMIT_P -> m_data stable at p, s_ready=0, no state change.
REQ-035 rst pulsed in EMIT_Q of a 4-pixel row -> all outputs 0 per REQ-026; next row [0x0400,0x0800] produces REQ-032 sequence.
REQ-036 With UPSAMPLE_ROW_NN_EN, nn_mode=1, row [0x0123, 0x0456] -> 0x0123, 0x0123, 0x0456, 0x0456.
REQ-037 8-pixel row, s_valid and m_ready constant 1 -> 16 outputs, 3 cycles per interior input pixel.
